// File: rtl/piso_serializer.sv
// Parallel-in serial-out transmitter: accepts a word on a valid/ready handshake and shifts it out MSB first.
// Define PISO_PARITY_EN to append an even-parity bit after the data bits of every frame.
module piso_serializer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] pin,
    input  logic             pin_valid,
    output logic             pin_ready,
    output logic             sout,
    output logic             sout_valid,
    output logic             sout_last,
    output logic             busy
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

`ifdef PISO_PARITY_EN
    typedef enum logic [1:0] {IDLE, SHIFT, PARITY} state_t;
`else
    typedef enum logic {IDLE, SHIFT} state_t;
`endif

    state_t           state_q, state_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             sout_q, sout_d;
    logic             valid_q, valid_d;
    logic             last_q, last_d;
    logic             ready_q, ready_d;
    logic             accept;
    logic             loadWord;
`ifdef PISO_PARITY_EN
    logic             par_q, par_d;
`endif

    assign accept = pin_valid && ready_q;

    always_comb begin
        state_d  = state_q;
        shift_d  = shift_q;
        cnt_d    = cnt_q;
        loadWord = 1'b0;
`ifdef PISO_PARITY_EN
        par_d    = par_q;
`endif
        case (state_q)
            IDLE: begin
                if (accept) loadWord = 1'b1;
            end
            SHIFT: begin
                if (cnt_q == LAST_IDX) begin
                    if (accept) begin
                        loadWord = 1'b1;
                    end else begin
`ifdef PISO_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = IDLE;
`endif
                    end
                end else begin
                    shift_d = {shift_q[WIDTH-2:0], 1'b0};
                    cnt_d   = cnt_q + CW'(1);
                end
            end
`ifdef PISO_PARITY_EN
            PARITY: begin
                if (accept) loadWord = 1'b1;
                else        state_d  = IDLE;
            end
`endif
            default: state_d = IDLE;
        endcase

        // A reload on the final-bit edge keeps the state in SHIFT so frames run gapless.
        if (loadWord) begin
            state_d = SHIFT;
            shift_d = pin;
            cnt_d   = '0;
`ifdef PISO_PARITY_EN
            par_d   = ^pin;
`endif
        end
    end

    // Output flags are computed from the next state so that every output is a flop.
    always_comb begin
        valid_d = (state_d != IDLE);
        sout_d  = 1'b0;
        last_d  = 1'b0;
        if (state_d == SHIFT) begin
            sout_d = shift_d[WIDTH-1];
`ifndef PISO_PARITY_EN
            last_d = (cnt_d == LAST_IDX);
`endif
        end
`ifdef PISO_PARITY_EN
        if (state_d == PARITY) begin
            sout_d = par_d;
            last_d = 1'b1;
        end
`endif
        ready_d = (state_d == IDLE) || last_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            shift_q <= '0;
            cnt_q   <= '0;
            sout_q  <= 1'b0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            ready_q <= 1'b1;
`ifdef PISO_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            sout_q  <= sout_d;
            valid_q <= valid_d;
            last_q  <= last_d;
            ready_q <= ready_d;
`ifdef PISO_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    assign pin_ready  = ready_q;
    assign sout       = sout_q;
    assign sout_valid = valid_q;
    assign sout_last  = last_q;
    assign busy       = valid_q;

endmodule

// File: tb/tb_piso_serializer.sv
// Directed testbench for piso_serializer; frame expectations switch with PISO_PARITY_EN.
module tb_piso_serializer;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] pin;
    logic       pin_valid;
    logic       pin_ready;
    logic       sout;
    logic       sout_valid;
    logic       sout_last;
    logic       busy;

    int checks = 0;
    int errors = 0;

`ifdef PISO_PARITY_EN
    localparam int         FLEN   = 9;
    localparam logic [8:0] EXP_AB = 9'b101010111;
    localparam logic [8:0] EXP_56 = 9'b010101100;
    localparam logic [8:0] EXP_FF = 9'b111111110;
    localparam logic [8:0] EXP_0F = 9'b000011110;
`else
    localparam int         FLEN   = 8;
    localparam logic [8:0] EXP_AB = 9'b010101011;
    localparam logic [8:0] EXP_56 = 9'b001010110;
    localparam logic [8:0] EXP_FF = 9'b011111111;
    localparam logic [8:0] EXP_0F = 9'b000001111;
`endif

    typedef struct {
        logic       pv;
        logic [7:0] pin;
        logic       ready;
        logic       sout;
        logic       valid;
        logic       last;
    } vec_t;

    vec_t vecs[$];

    piso_serializer #(.WIDTH(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .pin        (pin),
        .pin_valid  (pin_valid),
        .pin_ready  (pin_ready),
        .sout       (sout),
        .sout_valid (sout_valid),
        .sout_last  (sout_last),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic checkAll(input string tag, input logic ready, input logic so,
                            input logic valid, input logic last);
        checkOutput({tag, " pin_ready"}, pin_ready, ready);
        checkOutput({tag, " sout"}, sout, so);
        checkOutput({tag, " sout_valid"}, sout_valid, valid);
        checkOutput({tag, " sout_last"}, sout_last, last);
        checkOutput({tag, " busy"}, busy, valid);
    endtask

    task automatic addVec(input logic pv, input logic [7:0] p, input logic ready,
                          input logic so, input logic valid, input logic last);
        vec_t v;
        v.pv = pv; v.pin = p; v.ready = ready; v.sout = so; v.valid = valid; v.last = last;
        vecs.push_back(v);
    endtask

    // One vector per frame bit; pv0/pin0 drive the accepting edge, pvR/pinR the rest.
    task automatic addFrame(input logic pv0, input logic [7:0] pin0, input logic pvR,
                            input logic [7:0] pinR, input logic [8:0] bits);
        for (int i = 0; i < FLEN; i++) begin
            addVec((i == 0) ? pv0 : pvR, (i == 0) ? pin0 : pinR,
                   (i == FLEN - 1), bits[FLEN-1-i], 1'b1, (i == FLEN - 1));
        end
    endtask

    task automatic applyStimulus(input logic pv, input logic [7:0] p);
        pin_valid = pv;
        pin       = p;
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Single frame, back-to-back pair, busy rejection followed by the pending word.
        addFrame(1'b1, 8'hAB, 1'b0, 8'h00, EXP_AB);
        addVec(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
        addFrame(1'b1, 8'hAB, 1'b1, 8'hAB, EXP_AB);
        addFrame(1'b1, 8'h56, 1'b0, 8'h00, EXP_56);
        addVec(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
        addFrame(1'b1, 8'hAB, 1'b1, 8'hFF, EXP_AB);
        addFrame(1'b1, 8'hFF, 1'b0, 8'h00, EXP_FF);
        addVec(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);

        rst       = 1'b1;
        pin_valid = 1'b1;
        pin       = 8'h55;
        @(posedge clk);
        @(posedge clk);
        #1;
        checkAll("reset", 1'b1, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].pv, vecs[i].pin);
            checkAll($sformatf("vec%0d", i), vecs[i].ready, vecs[i].sout,
                     vecs[i].valid, vecs[i].last);
        end

        // Mid-frame reset: outputs must drop before the next clock edge.
        applyStimulus(1'b1, 8'hAB);
        for (int i = 1; i <= 3; i++) applyStimulus(1'b0, 8'h00);
        checkAll("bit3 before reset", 1'b0, EXP_AB[FLEN-4], 1'b1, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        checkAll("async reset", 1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 8'hAB);
        checkAll("held reset", 1'b1, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        for (int i = 0; i < FLEN; i++) begin
            applyStimulus((i == 0), (i == 0) ? 8'h0F : 8'h00);
            checkAll($sformatf("post-reset bit%0d", i), (i == FLEN - 1),
                     EXP_0F[FLEN-1-i], 1'b1, (i == FLEN - 1));
        end
        applyStimulus(1'b0, 8'h00);
        checkAll("post-reset idle", 1'b1, 1'b0, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
